// File: rtl/pe_pkg.sv
// Shared definitions for the PE MAC sequencer: default widths and FSM states.
package pe_pkg;

  localparam int ACC_W  = 32;
  localparam int W_W    = 8;
  localparam int WAIT_W = 3;   // holds PE latencies 1..7

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } pe_state_e;

endpackage

// File: rtl/pe_wait_counter.sv
// Down-counter timing the external PE latency; flags the last wait cycle.
module pe_wait_counter
  import pe_pkg::*;
#(
  parameter int CNT_W = WAIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_count;

  // Load on operand issue, then count down to zero and park there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Terminal count at 1: the PE result is valid during this cycle.
  assign o_expired = (r_count == CNT_W'(1));

endmodule

// File: rtl/pe_mac_sequencer.sv
// Feeds operand pairs one at a time into an external MAC PE, threads the
// running partial sum through it and returns the final sum to a consumer.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no job; waits for start, loads bias and length
// ST_FETCH | in_ready high; registers the next operand pair onto the PE
// ST_WAIT  | PE inputs held; waits PE_LAT-1 cycles, then captures the sum
// ST_DONE  | res_valid high with the final sum until res_ready
module pe_mac_sequencer
  import pe_pkg::*;
#(
  parameter int accumulationPar = ACC_W,
  parameter int weightPar       = W_W,
  parameter int PE_LAT          = 2,
  parameter int LEN_W           = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LEN_W-1:0]           len,
  input  logic [accumulationPar-1:0] bias,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [weightPar-1:0]       in_act,
  input  logic [weightPar-1:0]       in_wgt,
  output logic [weightPar-1:0]       pe_activation,
  output logic [weightPar-1:0]       pe_weight,
  output logic [accumulationPar-1:0] pe_inPartialSum,
  input  logic [accumulationPar-1:0] pe_outPartialSum,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [accumulationPar-1:0] res_data
);

  pe_state_e                  r_state;
  pe_state_e                  w_state_nxt;
  logic                       w_job_load;
  logic                       w_fire;
  logic                       w_capture;
  logic                       w_expired;
  logic [accumulationPar-1:0] r_acc;
  logic [LEN_W-1:0]           r_cnt;
  logic [weightPar-1:0]       r_act;
  logic [weightPar-1:0]       r_wgt;
  logic [accumulationPar-1:0] r_psum;

  // The sequencer's own operand register counts as the first PE stage, so
  // the wait timer starts at PE_LAT and one pair takes PE_LAT+1 cycles.
  pe_wait_counter #(.CNT_W(WAIT_W)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_fire),
    .i_load_val (WAIT_W'(PE_LAT)),
    .o_expired  (w_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_job_load  = 1'b0;
    w_fire      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_job_load  = 1'b1;
          w_state_nxt = (len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (in_valid) begin
          w_fire      = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_expired) begin
          w_capture   = 1'b1;
          w_state_nxt = (r_cnt > LEN_W'(1)) ? ST_FETCH : ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Accumulator, pair counter and held PE operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_act  <= '0;
      r_wgt  <= '0;
      r_psum <= '0;
    end else begin
      if (w_job_load) begin
        r_acc <= bias;
        r_cnt <= len;
      end
      if (w_fire) begin
        r_act  <= in_act;
        r_wgt  <= in_wgt;
        r_psum <= r_acc;
      end
      if (w_capture) begin
        r_acc <= pe_outPartialSum;
        r_cnt <= r_cnt - LEN_W'(1);
      end
    end
  end

  assign busy            = (r_state != ST_IDLE);
  assign in_ready        = (r_state == ST_FETCH);
  assign res_valid       = (r_state == ST_DONE);
  assign res_data        = r_acc;
  assign pe_activation   = r_act;
  assign pe_weight       = r_wgt;
  assign pe_inPartialSum = r_psum;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Directed bench: sequencer paired with a behavioural PE of latency 2.
module tb_pe_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [31:0] bias = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_act = '0;
  logic [7:0]  in_wgt = '0;
  logic [7:0]  pe_activation;
  logic [7:0]  pe_weight;
  logic [31:0] pe_inPartialSum;
  logic [31:0] pe_outPartialSum;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int res_cnt = 0;
  bit saw_ready = 1'b0;
  bit saw_res_valid = 1'b0;
  int hs_t[$];

  always #5 clk = ~clk;

  pe_mac_sequencer #(
    .accumulationPar(32), .weightPar(8), .PE_LAT(2), .LEN_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt),
    .pe_activation(pe_activation), .pe_weight(pe_weight),
    .pe_inPartialSum(pe_inPartialSum), .pe_outPartialSum(pe_outPartialSum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  // PE model: the sequencer's operand register is stage one, this is stage two.
  always_ff @(posedge clk) begin
    if (rst) pe_outPartialSum <= '0;
    else     pe_outPartialSum <= pe_inPartialSum + 32'(pe_activation) * 32'(pe_weight);
  end

  always @(posedge clk) begin
    cyc++;
    if (in_valid && in_ready) hs_t.push_back(cyc);
    if (res_valid && res_ready) res_cnt++;
    if (in_ready) saw_ready = 1'b1;
    if (res_valid) saw_res_valid = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] b, input logic [7:0] l);
    start = 1'b1; bias = b; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] w);
    int n;
    in_valid = 1'b1; in_act = a; in_wgt = w;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(output logic [31:0] d);
    int n;
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    chk("res_valid_wait", {31'd0, res_valid}, 32'd1);
    d = res_data;
  endtask

  initial begin
    logic [31:0] d;
    int rc;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_pe_act", {24'd0, pe_activation}, 32'd0);
    chk("rst_pe_wgt", {24'd0, pe_weight}, 32'd0);
    chk("rst_pe_psum", pe_inPartialSum, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic job: 2*3 + 4*5 + 1*1 = 27, pairs every PE_LAT+1 = 3 cycles
    hs_t.delete();
    rc = res_cnt;
    start_job(32'd0, 8'd3);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    send_pair(8'd2, 8'd3);
    send_pair(8'd4, 8'd5);
    chk("t1_pe_psum", pe_inPartialSum, 32'd6);
    send_pair(8'd1, 8'd1);
    wait_res(d);
    chk("t1_res", d, 32'd27);
    chk("t1_gap01", 32'(hs_t[1] - hs_t[0]), 32'd3);
    chk("t1_gap12", 32'(hs_t[2] - hs_t[1]), 32'd3);
    @(negedge clk);
    chk("t1_res_valid_fall", {31'd0, res_valid}, 32'd0);
    chk("t1_res_once", 32'(res_cnt - rc), 32'd1);

    // len=0 returns bias straight away, never asks for operands
    saw_ready = 1'b0;
    start_job(32'd100, 8'd0);
    chk("t2_res_valid", {31'd0, res_valid}, 32'd1);
    chk("t2_res", res_data, 32'd100);
    @(negedge clk);
    chk("t2_no_ready", {31'd0, saw_ready}, 32'd0);

    // gaps on in_valid: PE inputs hold; 10 + 3*4 + 5*6 = 52
    start_job(32'd10, 8'd2);
    send_pair(8'd3, 8'd4);
    repeat (5) @(negedge clk);
    chk("t3_gap_ready", {31'd0, in_ready}, 32'd1);
    chk("t3_gap_act", {24'd0, pe_activation}, 32'd3);
    chk("t3_gap_wgt", {24'd0, pe_weight}, 32'd4);
    chk("t3_gap_psum", pe_inPartialSum, 32'd10);
    send_pair(8'd5, 8'd6);
    wait_res(d);
    chk("t3_res", d, 32'd52);
    @(negedge clk);

    // consumer stall: 5 + 2*2 = 9 held for 10 cycles, start in DONE ignored
    res_ready = 1'b0;
    rc = res_cnt;
    start_job(32'd5, 8'd1);
    send_pair(8'd2, 8'd2);
    wait_res(d);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        start = 1'b1; bias = 32'd77; len = 8'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk("t4_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("t4_hold_data", res_data, 32'd9);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("t4_res_valid_fall", {31'd0, res_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_idle", {31'd0, busy}, 32'd0);
    chk("t4_res_once", 32'(res_cnt - rc), 32'd1);

    // reset during the second WAIT of a len=4 job
    rc = res_cnt;
    start_job(32'd0, 8'd4);
    send_pair(8'd1, 8'd1);
    send_pair(8'd2, 8'd2);
    chk("t5_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_res_valid", {31'd0, res_valid}, 32'd0);
    chk("t5_res_data", res_data, 32'd0);
    chk("t5_pe_act", {24'd0, pe_activation}, 32'd0);
    chk("t5_pe_wgt", {24'd0, pe_weight}, 32'd0);
    chk("t5_pe_psum", pe_inPartialSum, 32'd0);
    saw_res_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_no_result", {31'd0, saw_res_valid}, 32'd0);
    chk("t5_res_cnt", 32'(res_cnt - rc), 32'd0);
    start_job(32'd0, 8'd1);
    send_pair(8'd7, 8'd7);
    wait_res(d);
    chk("t5_after_rst", d, 32'd49);
    @(negedge clk);

    // accumulator wraps modulo 2^32
    start_job(32'hFFFF_FFFF, 8'd1);
    send_pair(8'd1, 8'd1);
    wait_res(d);
    chk("t6_wrap", d, 32'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pe_mac_sequencer.md
PE_MAC_SEQUENCER -- requirements
Module: pe_mac_sequencer

Interface
REQ-001 Parameter accumulationPar, default 32, SHALL set the partial-sum width.
REQ-002 Parameter weightPar, default 8, SHALL set the activation/weight width.
REQ-003 Parameter PE_LAT, default 2, SHALL set the cycles from PE input to valid outPartialSum, legal 1..7.
REQ-004 Parameter LEN_W, default 8, SHALL set the job-length counter width.
REQ-005 Ports SHALL be, in order:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request, accepted only in IDLE.
- len  in  LEN_W  number of MAC pairs in the job.
- bias  in  accumulationPar  initial partial sum.
- busy  out  1  high while not in IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts operand pair.
- in_act  in  weightPar  activation operand.
- in_wgt  in  weightPar  weight operand.
- pe_activation  out  weightPar  to PE activation.
- pe_weight  out  weightPar  to PE weight.
- pe_inPartialSum  out  accumulationPar  to PE inPartialSum.
- pe_outPartialSum  in  accumulationPar  from PE outPartialSum.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  accumulationPar  final accumulated sum.

Function
REQ-006 FSM states SHALL be IDLE, FETCH, WAIT, DONE.
REQ-007 IDLE: start=1 SHALL load acc<=bias, cnt<=len and go to FETCH, or to DONE if len=0.
REQ-008 FETCH: in_ready SHALL be 1; on in_valid&in_ready, the operands SHALL be registered onto pe_activation/pe_weight, pe_inPartialSum SHALL equal acc, wait counter<=PE_LAT, and the FSM SHALL go to WAIT.
REQ-009 in_ready SHALL be 0 in every state other than FETCH.
REQ-010 WAIT: PE inputs SHALL be held stable; when the wait counter expires, acc<=pe_outPartialSum, cnt<=cnt-1, then FETCH if cnt>1, else DONE.
REQ-011 One MAC pair SHALL complete every PE_LAT+1 cycles when in_valid is held high; no pipelining of pairs.
REQ-012 DONE: res_valid=1 and res_data=acc SHALL hold stable until res_ready=1, then the FSM SHALL go to IDLE.
REQ-013 The len=0 job SHALL return res_data=bias.
REQ-014 start outside IDLE SHALL be ignored with no effect on the job in progress.
REQ-015 The accumulator SHALL wrap modulo 2^accumulationPar; the sequencer SHALL perform no arithmetic beyond capturing the PE result.
REQ-016 pe_* outputs SHALL hold their last values in IDLE and DONE.
REQ-017 res_valid SHALL fall in the cycle after the res_ready handshake; a new start SHALL be accepted no earlier than the next IDLE cycle.

Reset
REQ-018 rst=1 at posedge SHALL force IDLE; busy, in_ready and res_valid SHALL be 0; res_data, acc, cnt and pe_* outputs SHALL be 0.
REQ-019 rst mid-job SHALL abort the job with no result produced; in-flight PE output SHALL be discarded.

Structure
REQ-020 A shared package pe_pkg SHALL hold the FSM state enum and default widths (ACC_W=32, W_W=8).
REQ-021 The existing PE SHALL remain external and wired by the parent; the sequencer SHALL contain no sub-modules beyond an optional pe_wait_counter.

Verification
REQ-022 Bench SHALL pair the DUT with the existing PE (PE_LAT=2) and cover:
- bias=0, len=3, pairs (2,3),(4,5),(1,1) -> res_data=27, res_valid once.
- bias=100, len=0 -> res_data=100 within 2 cycles of start; in_ready never 1.
- len=2 with in_valid gaps of 5 cycles -> PE inputs stable through gaps; result unaffected.
- res_ready held low 10 cycles in DONE -> res_valid and res_data stable; second start ignored.
- rst asserted during second WAIT of a len=4 job -> all outputs 0 next cycle; no res_valid; a following job len=1 (7,7) with bias=0 -> 49.
- bias=0xFFFFFFFF, len=1, pair (1,1) -> res_data=0 (wrap).
